// File: rtl/vram_arb_pkg.sv
// Shared types for the display RAM arbiter: FSM states, RAM-owner tags, out-of-window read value.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ISSUE,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VDU,
        OWN_CPU
    } owner_e;

    localparam logic [7:0] RDATA_OOW = 8'hFF;

    function automatic logic [15:0] umax16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vram_addr_window.sv
// Absolute 16-bit address -> RAM offset plus in-window flag; purely combinational, no flow control.
module vram_addr_window
    import vram_arb_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          ADDR_W    = 9,
    parameter int          DEPTH     = 512
) (
    input  logic [15:0]       abs_addr_i,
    output logic [ADDR_W-1:0] offset_o,
    output logic              in_win_o
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [15:0] rel;

    // Unsigned wrap: addresses below BASE_ADDR become huge offsets and fall out of window.
    assign rel      = abs_addr_i - BASE_ADDR;
    assign offset_o = rel[ADDR_W-1:0];
    assign in_win_o = ({1'b0, rel} < DEPTH_L);

endmodule

// File: rtl/vram_arbiter.sv
// Shares a 1-cycle-latency display RAM: VDU reads take the port unconditionally, CPU fills idle cycles.
// CPU ack 3 cycles after req (2 if out-of-window), +1 per VDU-busy cycle; optional VRAM_ARB_WAITSTAT_EN adds cpu_wait_max.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          ADDR_W    = 9,
    parameter int          DEPTH     = 512,
    parameter int          WAIT_W    = 16
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              vdu_read_en,
    input  logic [15:0]       vdu_read_addr,
    output logic [7:0]        vdu_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
`ifdef VRAM_ARB_WAITSTAT_EN
    output logic [WAIT_W-1:0] cpu_wait_max,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    arb_state_e        state_q;
    owner_e            owner_q;
    logic              req_we_q;
    logic [15:0]       req_addr_q;
    logic [7:0]        req_wdata_q;
    logic              cpu_ack_q;
    logic [7:0]        cpu_rdata_q;

    logic [ADDR_W-1:0] vdu_off;
    logic [ADDR_W-1:0] cpu_off;
    logic              vdu_in_win_unused;
    logic              cpu_in_win;
    logic              cpu_issue;

    vram_addr_window #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH)
    ) u_vdu_win (
        .abs_addr_i (vdu_read_addr),
        .offset_o   (vdu_off),
        .in_win_o   (vdu_in_win_unused)
    );

    vram_addr_window #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH)
    ) u_cpu_win (
        .abs_addr_i (req_addr_q),
        .offset_o   (cpu_off),
        .in_win_o   (cpu_in_win)
    );

    assign cpu_issue = (state_q == PEND) && cpu_in_win && !vdu_read_en;

    // VDU timing is fixed, so its strobe goes straight to the RAM with no register stage.
    always_comb begin
        mem_en    = vdu_read_en | cpu_issue;
        mem_we    = cpu_issue & req_we_q;
        mem_addr  = vdu_read_en ? vdu_off : cpu_off;
        mem_wdata = req_wdata_q;
    end

    assign vdu_data  = mem_rdata;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            req_we_q    <= 1'b0;
            req_addr_q  <= 16'h0000;
            req_wdata_q <= 8'h00;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
        end else begin
            cpu_ack_q <= 1'b0;
            if (vdu_read_en) begin
                owner_q <= OWN_VDU;
            end else if (cpu_issue) begin
                owner_q <= OWN_CPU;
            end else begin
                owner_q <= OWN_NONE;
            end

            case (state_q)
                IDLE: begin
                    if (cpu_req && !cpu_ack_q) begin
                        req_we_q    <= cpu_we;
                        req_addr_q  <= cpu_addr;
                        req_wdata_q <= cpu_wdata;
                        state_q     <= PEND;
                    end
                end
                PEND: begin
                    if (!cpu_in_win) begin
                        cpu_rdata_q <= RDATA_OOW;
                        cpu_ack_q   <= 1'b1;
                        state_q     <= RESP;
                    end else if (!vdu_read_en) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (owner_q == OWN_CPU && !req_we_q) begin
                        cpu_rdata_q <= mem_rdata;
                    end
                    cpu_ack_q <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_ARB_WAITSTAT_EN
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_max_q;

    // Counts stalled PEND cycles; the issuing cycle itself is not a wait.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            wait_cnt_q <= '0;
            wait_max_q <= '0;
        end else if (state_q == PEND) begin
            if (!cpu_in_win) begin
                wait_cnt_q <= '0;
            end else if (cpu_issue) begin
                if (wait_cnt_q > wait_max_q) begin
                    wait_max_q <= wait_cnt_q;
                end
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != '1) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    assign cpu_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 512-byte RAM (1-cycle read latency).
module tb_vram_arbiter;

    logic        clk_pix = 1'b0;
    logic        rst_pix;
    logic        vdu_read_en;
    logic [15:0] vdu_read_addr;
    logic [7:0]  vdu_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
`ifdef VRAM_ARB_WAITSTAT_EN
    logic [15:0] cpu_wait_max;
`endif
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk_pix = ~clk_pix;

    vram_arbiter dut (
        .clk_pix       (clk_pix),
        .rst_pix       (rst_pix),
        .vdu_read_en   (vdu_read_en),
        .vdu_read_addr (vdu_read_addr),
        .vdu_data      (vdu_data),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .cpu_rdata     (cpu_rdata),
`ifdef VRAM_ARB_WAITSTAT_EN
        .cpu_wait_max  (cpu_wait_max),
`endif
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // RAM contents after load: ram[i] = i[7:0] ^ 8'h3C.
    logic [7:0] ram [0:511];
    logic       ram_load;

    always @(posedge clk_pix) begin
        if (ram_load) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'(i) ^ 8'h3C;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // One CPU transaction; VDU reads vbase+k during intervals k=1..nvdu.
    task automatic cpu_xfer(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            input int nvdu, input logic [15:0] vbase,
                            output int lat, output int issue_at, output logic [7:0] rd,
                            output logic iss_we, output logic [8:0] iss_addr, output logic [7:0] iss_wd);
        logic got_ack;
        lat = 0; issue_at = -1; rd = 8'h00; got_ack = 1'b0;
        iss_we = 1'b0; iss_addr = 9'h000; iss_wd = 8'h00;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; vdu_read_en = 1'b0;
        #1;
        while (lat < 40) begin
            tick();
            lat++;
            if (lat == 1) begin
                cpu_addr = 16'h0123; cpu_wdata = 8'h5A; cpu_we = ~we;
            end
            vdu_read_en   = (lat <= nvdu);
            vdu_read_addr = vbase + 16'(lat);
            #1;
            if (lat >= 2 && lat - 1 <= nvdu)
                chk("vdu_data", 32'(vdu_data), 32'((vbase[7:0] + 8'(lat - 1)) ^ 8'h3C));
            if (vdu_read_en) begin
                chk("vdu_owns_we", 32'(mem_we), 32'd0);
                chk("vdu_owns_addr", 32'(mem_addr), 32'(9'(vbase + 16'(lat))));
            end else if (mem_en && issue_at < 0) begin
                issue_at = lat; iss_we = mem_we; iss_addr = mem_addr; iss_wd = mem_wdata;
            end
            if (cpu_ack) begin
                rd = cpu_rdata; got_ack = 1'b1;
                break;
            end
        end
        if (!got_ack) chk("ack_timeout", 32'd0, 32'd1);
        cpu_req = 1'b0; vdu_read_en = 1'b0;
        tick();
        chk("ack_pulse", 32'(cpu_ack), 32'd0);
    endtask

    int         lat, iss;
    logic [7:0] rd, iwd;
    logic       iw;
    logic [8:0] ia;
    logic       seen;

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_pix = 1'b1; ram_load = 1'b1;
        vdu_read_en = 1'b0; vdu_read_addr = 16'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        tick(); tick();
        ram_load = 1'b0;
        tick();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h00);
`ifdef VRAM_ARB_WAITSTAT_EN
        chk("rst_wait_max", 32'(cpu_wait_max), 32'd0);
`endif
        rst_pix = 1'b0;
        tick();
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_ack", 32'(cpu_ack), 32'd0);

        // Uncontended write then VDU read-back of the same byte.
        cpu_xfer(1'b1, 16'h0003, 8'hA5, 0, 16'h0000, lat, iss, rd, iw, ia, iwd);
        chk("wr_lat", lat, 3);
        chk("wr_issue_at", iss, 1);
        chk("wr_mem_we", 32'(iw), 32'd1);
        chk("wr_mem_addr", 32'(ia), 32'd3);
        chk("wr_mem_wdata", 32'(iwd), 32'hA5);
        vdu_read_en = 1'b1; vdu_read_addr = 16'h0003;
        tick();
        vdu_read_en = 1'b0;
        #1;
        chk("vdu_after_wr", 32'(vdu_data), 32'hA5);

        cpu_xfer(1'b0, 16'h0003, 8'h00, 0, 16'h0000, lat, iss, rd, iw, ia, iwd);
        chk("rd_lat", lat, 3);
        chk("rd_data", 32'(rd), 32'hA5);
        chk("rd_mem_we", 32'(iw), 32'd0);
        chk("rd_mem_addr", 32'(ia), 32'd3);

        // VDU busy for 4 cycles: issue slips to t+5, ack to t+7.
        cpu_xfer(1'b0, 16'h0040, 8'h00, 4, 16'h0100, lat, iss, rd, iw, ia, iwd);
        chk("cont_issue_at", iss, 5);
        chk("cont_lat", lat, 7);
        chk("cont_data", 32'(rd), 32'h7C);

        // Out-of-window: above the top and wrapped below the base.
        cpu_xfer(1'b0, 16'h0200, 8'h00, 0, 16'h0000, lat, iss, rd, iw, ia, iwd);
        chk("oow_hi_issue", iss, -1);
        chk("oow_hi_lat", lat, 2);
        chk("oow_hi_data", 32'(rd), 32'hFF);
        cpu_xfer(1'b0, 16'hFFFF, 8'h00, 0, 16'h0000, lat, iss, rd, iw, ia, iwd);
        chk("oow_wrap_issue", iss, -1);
        chk("oow_wrap_lat", lat, 2);
        chk("oow_wrap_data", 32'(rd), 32'hFF);
        cpu_xfer(1'b1, 16'h0200, 8'h77, 0, 16'h0000, lat, iss, rd, iw, ia, iwd);
        chk("oow_wr_issue", iss, -1);
        chk("oow_wr_lat", lat, 2);
        cpu_xfer(1'b0, 16'h0000, 8'h00, 0, 16'h0000, lat, iss, rd, iw, ia, iwd);
        chk("oow_wr_ram0", 32'(rd), 32'h3C);
        chk("ram0_lat", lat, 3);

        // Reset while the request is stalled in PEND.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        vdu_read_en = 1'b1; vdu_read_addr = 16'h0150;
        tick();
        tick();
        rst_pix = 1'b1; cpu_req = 1'b0;
        tick();
        rst_pix = 1'b0; vdu_read_en = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (cpu_ack || mem_en) seen = 1'b1;
        end
        chk("rst_mid_no_ack", 32'(seen), 32'd0);
`ifdef VRAM_ARB_WAITSTAT_EN
        chk("rst_mid_wait_max", 32'(cpu_wait_max), 32'd0);
`endif
        cpu_xfer(1'b0, 16'h0003, 8'h00, 0, 16'h0000, lat, iss, rd, iw, ia, iwd);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", 32'(rd), 32'hA5);

        // Waits of 4 then 1 cycle.
        cpu_xfer(1'b0, 16'h0041, 8'h00, 4, 16'h0100, lat, iss, rd, iw, ia, iwd);
        chk("w4_issue_at", iss, 5);
        chk("w4_data", 32'(rd), 32'h7D);
`ifdef VRAM_ARB_WAITSTAT_EN
        chk("wait_max_4", 32'(cpu_wait_max), 32'd4);
`endif
        cpu_xfer(1'b0, 16'h0042, 8'h00, 1, 16'h0100, lat, iss, rd, iw, ia, iwd);
        chk("w1_issue_at", iss, 2);
        chk("w1_lat", lat, 4);
        chk("w1_data", 32'(rd), 32'h7E);
`ifdef VRAM_ARB_WAITSTAT_EN
        chk("wait_max_keep", 32'(cpu_wait_max), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous display RAM (1-cycle read latency) between the VDU fetch port and a CPU read/write port.
- VDU has absolute priority: its fetch timing is fixed, and display_data must arrive exactly one cycle after read_en.
- CPU accesses are slotted into cycles where the VDU does not read, using a req/ack handshake.
- Sits between vdu_hdmi_600p and the display RAM, in the pixel clock domain.

Parameters:
- BASE_ADDR, 16'h0000, CPU/VDU address of RAM byte 0.
- ADDR_W, 9, RAM address width.
- DEPTH, 512, RAM size in bytes (16x32 chars); must be ≤ 2**ADDR_W.
- WAIT_W, 16, width of the wait statistic counter (optional feature only).

Ports:
- clk_pix  in  1  pixel clock; sole clock.
- rst_pix  in  1  synchronous, active-high reset.
- vdu_read_en  in  1  VDU fetch strobe.
- vdu_read_addr  in  16  VDU fetch address (absolute).
- vdu_data  out  8  fetch data, valid the cycle after vdu_read_en.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  absolute CPU address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid while cpu_ack is high; held otherwise.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, 1-cycle latency.

Behaviour:
- **Reset values.** cpu_ack=0, cpu_rdata=8'h00, state=IDLE, owner pipe=NONE. mem_en/mem_we are 0 because the combinational mux sees vdu_read_en=0 and no CPU issue.
- **Address window.** An address is in-window when (addr − BASE_ADDR) < DEPTH, computed as an unsigned 16-bit subtraction so wrap-around below BASE_ADDR counts as out-of-window. The offset is truncated to ADDR_W bits.
- **VDU path (combinational mux).**
  - When vdu_read_en=1: mem_en=1, mem_we=0, mem_addr=VDU offset.
  - Out-of-window VDU reads still strobe the RAM with the truncated offset (no error).
  - vdu_data = mem_rdata every cycle. The VDU ignores it except the cycle after its own read_en.
- **FSM states:** IDLE, PEND, ISSUE, RESP.
  - IDLE: when cpu_req=1 and cpu_ack=0, latch we/addr/wdata → PEND.
  - PEND:
    - If the latched address is out-of-window: cpu_rdata←8'hFF, writes dropped, → RESP. No RAM access.
    - Else if vdu_read_en=0: issue this cycle (mem_en=1, mem_we=latched we, mem_addr/mem_wdata from the latch) → ISSUE.
    - Else: stay in PEND (VDU wins the simultaneous-request case).
  - ISSUE: mem_rdata now valid; capture into cpu_rdata (reads only; writes leave it unchanged) → RESP.
  - RESP: cpu_ack=1 for exactly this cycle → IDLE.
  - The cpu_req that is still high during the ack cycle is not re-latched, because of the cpu_ack=0 qualifier.
- **Latency.**
  - In-window access, no contention: req seen at cycle t, issue at t+1, ack at t+3.
  - Each VDU-occupied cycle while in PEND adds one cycle.
  - Out-of-window: ack at t+2.
- **Outstanding requests.** Only one CPU request is outstanding. cpu_addr/cpu_we/cpu_wdata may change after latching.
- **Starvation.** Unbounded waits are allowed. The VDU reads at most 1 cycle in 8, so the worst practical wait is bounded by the VDU cadence.
- **Write-then-read ordering.** A CPU write followed by a VDU read of the same offset returns the new byte; ordering is preserved by the RAM.
- **Reset mid-operation.** Any state → IDLE; the latched request is discarded with no ack, and the CPU must re-request. An ISSUE-cycle write already committed to RAM stays committed.

Optional Feature:
- VRAM_ARB_WAITSTAT_EN defined:
  - Adds output cpu_wait_max [WAIT_W-1:0], reset to 0.
  - A per-request counter increments each cycle spent in PEND and saturates at all-ones.
  - On ISSUE entry, cpu_wait_max ← max(cpu_wait_max, counter), and the counter clears.
  - Out-of-window requests do not update it.
- Undefined: the port and counters are absent. Functional timing is identical in both builds.

Decomposition:
- Package vram_arb_pkg: state enum (IDLE, PEND, ISSUE, RESP); localparam RDATA_OOW=8'hFF.
- One sub-module, vram_addr_window (combinational: absolute address → offset + in-window flag), instantiated twice (VDU, CPU).

Test Plan:
- Reset, then idle: mem_en=0, cpu_ack=0, cpu_rdata=00.
- CPU write 0xA5 to BASE_ADDR+3 with VDU idle: mem_we=1, mem_addr=3 at t+1; ack at t+3. A following CPU read returns A5 with ack.
- VDU read_en held high cycles t+1..t+4 while a CPU read is pending: no CPU issue during those cycles; issue at t+5, ack at t+7. vdu_data is correct on each following cycle.
- CPU read of BASE_ADDR+512 (out-of-window) and of BASE_ADDR−1 (wrap): no mem_en, ack at t+2, rdata=FF. An out-of-window write leaves RAM unchanged.
- Assert rst_pix during PEND: no ack ever arrives for that request, state returns to IDLE, and a new request completes normally.
- With VRAM_ARB_WAITSTAT_EN: waits of 4 then 1 cycles give cpu_wait_max=4; the build without the macro has no cpu_wait_max port.
